// File: rtl/tlu_dut_rx_if.sv
// tlu_dut_rx_if: TLU trigger handshake lines between master and DUT
// master drives TLU_TRIGGER/TLU_RESET, the DUT drives TLU_BUSY/TLU_CLOCK back.
interface tlu_dut_rx_if;
  logic TLU_TRIGGER;
  logic TLU_RESET;
  logic TLU_BUSY;
  logic TLU_CLOCK;
  modport master (output TLU_TRIGGER, TLU_RESET, input TLU_BUSY, TLU_CLOCK);
  modport slave (input TLU_TRIGGER, TLU_RESET, output TLU_BUSY, TLU_CLOCK);
endinterface

// File: rtl/tlu_dut_rx.sv
// tlu_dut_rx: DUT-side TLU trigger handshake receiver
// SYS_CLK/SYS_RST: sole clock, async active-high reset. ENABLE: accept new triggers.
// DUT_BUSY: local veto extending TLU_BUSY. tlu: TLU_TRIGGER/TLU_RESET in, TLU_BUSY/TLU_CLOCK out.
// TRIG_ID/TRIG_VALID: received number and its one-cycle strobe. TLU_RESET_SEEN: master reset pulse.
// TIMEOUT_ERR: sticky, set when the trigger line stays high too long after readout.
module tlu_dut_rx #(
  parameter int ID_BITS = 15,
  parameter int CLK_DIV = 4,
  parameter int TIMEOUT = 65535
) (
  input  logic               SYS_CLK,
  input  logic               SYS_RST,
  input  logic               ENABLE,
  input  logic               DUT_BUSY,
  tlu_dut_rx_if.slave        tlu,
  output logic [ID_BITS-1:0] TRIG_ID,
  output logic               TRIG_VALID,
  output logic               TLU_RESET_SEEN,
  output logic               TIMEOUT_ERR
);
  localparam int CW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam int BW = ID_BITS > 1 ? $clog2(ID_BITS) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CMAX = CW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BMAX = BW'(ID_BITS - 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);
  typedef enum logic [2:0] {IDLE, BUSY_WAIT, CLK_HI, CLK_LO, DONE, WAIT_LOW} state_t;
  state_t state, nxt;
  logic [1:0] trg_s;
  logic [2:0] rst_s;
  logic [CW-1:0] cnt;
  logic [BW-1:0] bcnt;
  logic [TW-1:0] tmo;
  logic [ID_BITS-1:0] sr;
  logic trg, last, bdone, tdone;
  assign trg = trg_s[1];
  assign last = cnt == CMAX;
  assign bdone = bcnt == BMAX;
  assign tdone = tmo == TMAX;
  always_ff @(posedge SYS_CLK or posedge SYS_RST)
    if (SYS_RST) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:      nxt = ENABLE && trg ? BUSY_WAIT : IDLE;
      BUSY_WAIT: nxt = last ? CLK_HI : BUSY_WAIT;
      CLK_HI:    nxt = last ? CLK_LO : CLK_HI;
      CLK_LO:    nxt = !last ? CLK_LO : bdone ? DONE : CLK_HI;
      DONE:      nxt = tdone && trg ? WAIT_LOW : !trg && !DUT_BUSY ? IDLE : DONE;
      WAIT_LOW:  nxt = trg ? WAIT_LOW : IDLE;
      default:   nxt = IDLE;
    endcase
  end
  // Busy and clock are registered from the next state so they change on the transition edge.
  always_ff @(posedge SYS_CLK or posedge SYS_RST)
    if (SYS_RST) begin
      trg_s <= '0;
      rst_s <= '0;
      cnt <= '0;
      bcnt <= '0;
      tmo <= '0;
      sr <= '0;
      TRIG_ID <= '0;
      TRIG_VALID <= 1'b0;
      TLU_RESET_SEEN <= 1'b0;
      TIMEOUT_ERR <= 1'b0;
      tlu.TLU_BUSY <= 1'b0;
      tlu.TLU_CLOCK <= 1'b0;
    end else begin
      trg_s <= {trg_s[0], tlu.TLU_TRIGGER};
      rst_s <= {rst_s[1:0], tlu.TLU_RESET};
      TLU_RESET_SEEN <= rst_s[1] & ~rst_s[2];
      cnt <= nxt != state ? '0 : cnt + 1'b1;
      if (state == BUSY_WAIT) bcnt <= '0;
      else if (state == CLK_LO && last && !bdone) bcnt <= bcnt + 1'b1;
      // The master has had the whole high phase to settle the bit, so sample at its end.
      if (state == CLK_HI && last) sr[bcnt] <= trg;
      tmo <= state != DONE ? '0 : tdone ? tmo : tmo + 1'b1;
      // tmo is zero only during the first DONE cycle, which makes the strobe one cycle wide.
      TRIG_VALID <= state == DONE && tmo == '0;
      if (state == DONE && tmo == '0) TRIG_ID <= sr;
      TIMEOUT_ERR <= TIMEOUT_ERR | (state == DONE && nxt == WAIT_LOW);
      tlu.TLU_BUSY <= nxt != IDLE && nxt != WAIT_LOW;
      tlu.TLU_CLOCK <= nxt == CLK_HI;
    end
endmodule
